// File: rtl/idex_pkg.sv
// Shared types and default widths for the ID->EX skid stage.
// Occupancy states, default payload widths and the default-width entry layout.
package idex_pkg;

  localparam int PC_W    = 12;
  localparam int INSTR_W = 12;
  localparam int SET_W   = 4;
  localparam int CNT_W   = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic [SET_W-1:0]   set;
  } entry_t;

endpackage

// File: rtl/pipe_entry_reg.sv
// Single payload register with load enable; clears to zero on async reset.
module pipe_entry_reg #(
  parameter int W = 28
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/idex_skid_stage.sv
// ID->EX boundary: valid/ready handshake over a main + skid register pair,
// with synchronous flush and a saturating back-pressure cycle counter.
module idex_skid_stage #(
  parameter int PC_W    = idex_pkg::PC_W,
  parameter int INSTR_W = idex_pkg::INSTR_W,
  parameter int SET_W   = idex_pkg::SET_W,
  parameter int CNT_W   = idex_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [SET_W-1:0]   in_set,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [SET_W-1:0]   out_set,
  output logic [CNT_W-1:0]   stall_cnt
);

  import idex_pkg::*;

  localparam int ENTRY_W = PC_W + INSTR_W + SET_W;

  state_t             state, state_next;
  logic               accept, deliver;
  logic               load_main, load_skid, main_from_skid;
  logic [ENTRY_W-1:0] in_entry, main_d, main_q, skid_q;

  // Both handshake outputs decode the registered state only, so in_ready
  // never depends combinationally on out_ready.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign deliver   = out_valid & out_ready;

  assign in_entry = {in_pc, in_instr, in_set};
  assign main_d   = main_from_skid ? skid_q : in_entry;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next     = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      // Anything accepted this cycle is dropped; registers keep stale payload.
      state_next = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            load_main  = 1'b1;
            state_next = BUSY;
          end
        end
        BUSY: begin
          if (accept && deliver) begin
            load_main = 1'b1;
          end else if (accept) begin
            load_skid  = 1'b1;
            state_next = FULL;
          end else if (deliver) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (deliver) begin
            load_main      = 1'b1;
            main_from_skid = 1'b1;
            state_next     = BUSY;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  pipe_entry_reg #(.W(ENTRY_W)) u_main (
    .clk  (clk),
    .rst  (rst),
    .load (load_main),
    .d    (main_d),
    .q    (main_q)
  );

  pipe_entry_reg #(.W(ENTRY_W)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .load (load_skid),
    .d    (in_entry),
    .q    (skid_q)
  );

  assign {out_pc, out_instr, out_set} = main_q;

  // Counts EX back-pressure cycles; sticks at all-ones and survives flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_idex_skid_stage.sv
// Scoreboard bench for idex_skid_stage: queue model of the two-entry buffer,
// directed back-pressure/flush/reset/saturation scenarios plus random traffic.
module tb_idex_skid_stage;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 24;
  localparam int SET_W   = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic [SET_W-1:0]   set;
  } txn_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [PC_W-1:0]    in_pc;
  logic [INSTR_W-1:0] in_instr;
  logic [SET_W-1:0]   in_set;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instr;
  logic [SET_W-1:0]   out_set;
  logic [CNT_W-1:0]   stall_cnt;

  int   vectors     = 0;
  int   miscompares = 0;
  txn_t sb[$];
  int   exp_stall   = 0;
  int   stall_snap;

  idex_skid_stage #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .SET_W(SET_W), .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_set    (in_set),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_set   (out_set),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [PC_W-1:0] pc, input logic ordy,
                       input logic fl = 1'b0);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = INSTR_W'(pc * 7 + 24'h100);
    in_set    = SET_W'(pc[3:0] + 8'h5);
    out_ready = ordy;
    flush     = fl;
  endtask

  // Called at a falling edge with inputs set; checks just before the rising
  // edge, updates the model for that edge, and returns at the next falling edge.
  task automatic cycle();
    logic m_valid, m_ready, acc, dlv;
    txn_t t;
    #4;
    m_valid = (sb.size() != 0);
    m_ready = (sb.size() < 2);
    acc     = in_valid && m_ready;
    dlv     = m_valid && out_ready;
    check("out_valid", 64'(out_valid), 64'(m_valid));
    check("in_ready", 64'(in_ready), 64'(m_ready));
    check("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
    if (dlv) begin
      t = sb.pop_front();
      check("out_pc", 64'(out_pc), 64'(t.pc));
      check("out_instr", 64'(out_instr), 64'(t.instr));
      check("out_set", 64'(out_set), 64'(t.set));
    end
    if (flush) begin
      sb.delete();
    end else if (acc) begin
      t.pc = in_pc; t.instr = in_instr; t.set = in_set;
      sb.push_back(t);
    end
    if (m_valid && !out_ready && exp_stall != CNT_MAX) exp_stall++;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, '0, 1'b0);
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_pc", 64'(out_pc), 64'd0);
    check("rst_stall", 64'(stall_cnt), 64'd0);
    rst = 1'b1;

    // Streaming at full rate, then drain; payload must hold after drain.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, PC_W'(32'h010 + i), 1'b1);
      cycle();
    end
    drive(1'b0, '0, 1'b1);
    repeat (2) cycle();
    check("hold_last_pc", 64'(out_pc), 64'h012);

    // Back-pressure: two accepts fill main+skid, then three hold cycles.
    drive(1'b1, 32'h020, 1'b0); cycle();
    drive(1'b1, 32'h021, 1'b0); cycle();
    check("bp_in_ready", 64'(in_ready), 64'd0);
    drive(1'b1, 32'h022, 1'b0);
    repeat (3) cycle();
    check("bp_stall4", 64'(stall_cnt), 64'd4);
    drive(1'b0, '0, 1'b1);
    repeat (3) cycle();
    check("bp_drained", 64'(sb.size()), 64'd0);

    // Flush in FULL with a deliver in the same cycle; 0x030 must vanish.
    drive(1'b1, 32'h040, 1'b0); cycle();
    drive(1'b1, 32'h041, 1'b0); cycle();
    stall_snap = int'(stall_cnt);
    drive(1'b1, 32'h030, 1'b1, 1'b1); cycle();
    check("fl_out_valid", 64'(out_valid), 64'd0);
    check("fl_in_ready", 64'(in_ready), 64'd1);
    check("fl_stall_kept", 64'(stall_cnt), 64'(stall_snap));
    drive(1'b0, '0, 1'b1);
    repeat (2) cycle();

    // Full-width payload.
    in_valid = 1'b1; in_pc = 32'hDEADBEEF; in_instr = 24'hA5A5A5; in_set = 8'h3C;
    out_ready = 1'b1; flush = 1'b0;
    cycle();
    check("wide_pc", 64'(out_pc), 64'hDEADBEEF);
    check("wide_instr", 64'(out_instr), 64'hA5A5A5);
    check("wide_set", 64'(out_set), 64'h3C);
    drive(1'b0, '0, 1'b1);
    cycle();

    // Asynchronous reset while FULL, asserted between clock edges.
    drive(1'b1, 32'h050, 1'b0); cycle();
    drive(1'b1, 32'h051, 1'b0); cycle();
    drive(1'b0, '0, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_out_pc", 64'(out_pc), 64'd0);
    check("arst_out_instr", 64'(out_instr), 64'd0);
    check("arst_out_set", 64'(out_set), 64'd0);
    check("arst_stall", 64'(stall_cnt), 64'd0);
    sb.delete();
    exp_stall = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Saturation: one entry held against EX for 20+ cycles.
    drive(1'b1, 32'h060, 1'b0); cycle();
    drive(1'b0, '0, 1'b0);
    repeat (20) cycle();
    check("sat_15", 64'(stall_cnt), 64'(CNT_MAX));
    repeat (2) cycle();
    check("sat_hold", 64'(stall_cnt), 64'(CNT_MAX));
    drive(1'b0, '0, 1'b1);
    repeat (2) cycle();

    // Random traffic with occasional flushes.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 3) != 0), PC_W'($urandom), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 19) == 0));
      cycle();
    end
    drive(1'b0, '0, 1'b1);
    repeat (3) cycle();
    check("final_empty", 64'(out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
